// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the four-entry vector register file.
// The random-fill feature is gated by REGFILE_RANDOM_SET_EN in register_file.
package regfile_pkg;

  localparam int unsigned VLEN_DEFAULT      = 512;
  localparam int unsigned NUM_REGS          = 4;
  localparam int unsigned ADDR_W            = 2;
  localparam logic [31:0] LFSR_TAPS         = 32'h8020_0003;
  localparam logic [31:0] LFSR_SEED_DEFAULT = 32'h0000_0001;
  localparam logic [31:0] MIX_CONST         = 32'h9E37_79B9;

  // Right-shifting Galois step; bit 31 is a tap, so a non-zero state stays non-zero.
  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    if (state[0]) begin
      return (state >> 1) ^ LFSR_TAPS;
    end
    return state >> 1;
  endfunction

  // Per-register decorrelation word: state ^ (idx * MIX_CONST), truncated to 32 bits.
  function automatic logic [31:0] mix_word(input logic [31:0] state,
                                           input logic [ADDR_W-1:0] idx);
    logic [31:0] w_scaled;
    w_scaled = 32'(idx) * MIX_CONST;
    return state ^ w_scaled;
  endfunction

endpackage

// File: rtl/regfile_lfsr.sv
// Free-running 32-bit Galois LFSR used as the random-fill source.
// Only instantiated when REGFILE_RANDOM_SET_EN is defined.
module regfile_lfsr
  import regfile_pkg::*;
#(
  parameter logic [31:0] SEED = LFSR_SEED_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] state
);

  logic [31:0] r_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= SEED;
    end else begin
      r_state <= lfsr_next(r_state);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/register_file.sv
// Four VLEN-bit vector registers with load, paired result write, read and store ports.
// Define REGFILE_RANDOM_SET_EN to build the LFSR-driven random_set fill.
module register_file
  import regfile_pkg::*;
#(
  parameter int unsigned VLEN      = VLEN_DEFAULT,
  parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr_reg,
  input  logic [VLEN-1:0]   load_data,
  input  logic              write_enable,
  input  logic [VLEN-1:0]   A3,
  input  logic [VLEN-1:0]   A4,
  input  logic              random_set,
  input  logic              read,
  input  logic              store,
  input  logic [ADDR_W-1:0] store_addr_reg,
  output logic [VLEN-1:0]   A1,
  output logic [VLEN-1:0]   A2,
  output logic [VLEN-1:0]   store_data
);

  localparam int unsigned WORDS = VLEN / 32;

  logic [NUM_REGS-1:0][VLEN-1:0] r_regs;
  logic [NUM_REGS-1:0][VLEN-1:0] w_regs_d;
  logic [VLEN-1:0]               r_a1;
  logic [VLEN-1:0]               r_a2;
  logic [VLEN-1:0]               r_store_data;

`ifdef REGFILE_RANDOM_SET_EN
  logic [31:0] w_lfsr;

  regfile_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .state (w_lfsr)
  );
`else
  logic w_unused_random_set;
  assign w_unused_random_set = random_set;
`endif

  // Later assignments override earlier ones: random_set > load > write_enable.
  always_comb begin
    w_regs_d = r_regs;
    if (write_enable) begin
      w_regs_d[2] = A3;
      w_regs_d[3] = A4;
    end
    if (load) begin
      w_regs_d[load_addr_reg] = load_data;
    end
`ifdef REGFILE_RANDOM_SET_EN
    if (random_set) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        w_regs_d[i] = {WORDS{mix_word(w_lfsr, ADDR_W'(i))}};
      end
    end
`endif
  end

  // Outputs sample pre-edge contents, so a write shows up one cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs       <= '0;
      r_a1         <= '0;
      r_a2         <= '0;
      r_store_data <= '0;
    end else begin
      r_regs <= w_regs_d;
      if (read) begin
        r_a1 <= r_regs[0];
        r_a2 <= r_regs[1];
      end
      if (store) begin
        r_store_data <= r_regs[store_addr_reg];
      end
    end
  end

  assign A1         = r_a1;
  assign A2         = r_a2;
  assign store_data = r_store_data;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: vector table plus reset and random-fill sequences.
// Honours REGFILE_RANDOM_SET_EN to pick the expected random_set behaviour.
module tb_register_file;

  localparam int VLEN = 512;

  typedef struct {
    string           name;
    bit              rs;
    bit              ld;
    bit [1:0]        la;
    logic [VLEN-1:0] ldd;
    bit              we;
    logic [VLEN-1:0] a3;
    logic [VLEN-1:0] a4;
    bit              rd;
    bit              st;
    bit [1:0]        sa;
    logic [VLEN-1:0] ea1;
    logic [VLEN-1:0] ea2;
    logic [VLEN-1:0] esd;
  } vec_t;

  typedef struct {
    string           name;
    logic [VLEN-1:0] a1;
    logic [VLEN-1:0] a2;
    logic [VLEN-1:0] sd;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            load = 1'b0;
  logic [1:0]      load_addr_reg = '0;
  logic [VLEN-1:0] load_data = '0;
  logic            write_enable = 1'b0;
  logic [VLEN-1:0] A3 = '0;
  logic [VLEN-1:0] A4 = '0;
  logic            random_set = 1'b0;
  logic            read = 1'b0;
  logic            store = 1'b0;
  logic [1:0]      store_addr_reg = '0;
  logic [VLEN-1:0] A1;
  logic [VLEN-1:0] A2;
  logic [VLEN-1:0] store_data;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  vec_t vecs[$];

  logic [31:0] m_lfsr;

  register_file #(
    .VLEN      (VLEN),
    .LFSR_SEED (32'h0000_0001)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .load           (load),
    .load_addr_reg  (load_addr_reg),
    .load_data      (load_data),
    .write_enable   (write_enable),
    .A3             (A3),
    .A4             (A4),
    .random_set     (random_set),
    .read           (read),
    .store          (store),
    .store_addr_reg (store_addr_reg),
    .A1             (A1),
    .A2             (A2),
    .store_data     (store_data)
  );

  always #5 clk = ~clk;

  // Independent reference LFSR: right-shift Galois, taps 0x80200003, seed 1.
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= 32'h0000_0001;
    else        m_lfsr <= m_lfsr[0] ? ((m_lfsr >> 1) ^ 32'h8020_0003) : (m_lfsr >> 1);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  function automatic logic [VLEN-1:0] rep(input logic [31:0] w);
    return {16{w}};
  endfunction

  function automatic void cmp(input string n, input logic [VLEN-1:0] got,
                              input logic [VLEN-1:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got %h want %h", n, got, want);
    end
  endfunction

  function automatic void check_true(input string n, input bit cond);
    n_tests++;
    if (!cond) begin
      n_fail++;
      $display("FAIL %s got 0 want 1", n);
    end
  endfunction

  function automatic vec_t mk(input string n, input bit rs, input bit ld, input bit [1:0] la,
                              input logic [VLEN-1:0] ldd, input bit we,
                              input logic [VLEN-1:0] a3, input logic [VLEN-1:0] a4,
                              input bit rd, input bit st, input bit [1:0] sa,
                              input logic [VLEN-1:0] ea1, input logic [VLEN-1:0] ea2,
                              input logic [VLEN-1:0] esd);
    vec_t v;
    v.name = n; v.rs = rs; v.ld = ld; v.la = la; v.ldd = ldd; v.we = we;
    v.a3 = a3; v.a4 = a4; v.rd = rd; v.st = st; v.sa = sa;
    v.ea1 = ea1; v.ea2 = ea2; v.esd = esd;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    random_set = v.rs; load = v.ld; load_addr_reg = v.la; load_data = v.ldd;
    write_enable = v.we; A3 = v.a3; A4 = v.a4; read = v.rd; store = v.st;
    store_addr_reg = v.sa;
    e.name = v.name; e.a1 = v.ea1; e.a2 = v.ea2; e.sd = v.esd;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check_true({v.name, "_sb_empty"}, 1'b0);
    end else begin
      e = sb.pop_front();
      cmp({e.name, "_a1"}, A1, e.a1);
      cmp({e.name, "_a2"}, A2, e.a2);
      cmp({e.name, "_sd"}, store_data, e.sd);
    end
  endtask

  task automatic idle_inputs();
    random_set = 0; load = 0; write_enable = 0; read = 0; store = 0;
  endtask

  logic [VLEN-1:0] Z, DB, P1, P2, P3, P4, P5, PF, CF;
  logic [VLEN-1:0] exp_r[4];
  logic [31:0]     mix[4];
  logic [31:0]     w_snap;

  initial begin
    Z  = '0;
    DB = rep(32'hDEAD_BEEF); P1 = rep(32'h1111_1111); P2 = rep(32'h2222_2222);
    P3 = rep(32'h3333_3333); P4 = rep(32'h4444_4444); P5 = rep(32'h5555_5555);
    PF = rep(32'h0F0F_0F0F); CF = rep(32'hCAFE_F00D);
    mix[0] = 32'h0000_0000; mix[1] = 32'h9E37_79B9;
    mix[2] = 32'h3C6E_F372; mix[3] = 32'hDAA6_6D2B;

    //            name       rs ld la ldd we a3  a4  rd st sa  ea1 ea2 esd
    vecs.push_back(mk("rst_st2", 0, 0, 0, Z,  0, Z,  Z,  0, 1, 2, Z,  Z,  Z));
    vecs.push_back(mk("load_r1", 0, 1, 1, DB, 0, Z,  Z,  0, 0, 0, Z,  Z,  Z));
    vecs.push_back(mk("read_r1", 0, 0, 0, Z,  0, Z,  Z,  1, 0, 0, Z,  DB, Z));
    vecs.push_back(mk("we_r23",  0, 0, 0, Z,  1, P1, P2, 0, 0, 0, Z,  DB, Z));
    vecs.push_back(mk("st_r2",   0, 0, 0, Z,  0, Z,  Z,  0, 1, 2, Z,  DB, P1));
    vecs.push_back(mk("st_r3",   0, 0, 0, Z,  0, Z,  Z,  0, 1, 3, Z,  DB, P2));
    vecs.push_back(mk("ld3_we",  0, 1, 3, P5, 1, P3, P4, 0, 1, 3, Z,  DB, P2));
    vecs.push_back(mk("st_r3b",  0, 0, 0, Z,  0, Z,  Z,  0, 1, 3, Z,  DB, P5));
    vecs.push_back(mk("st_r2b",  0, 0, 0, Z,  0, Z,  Z,  0, 1, 2, Z,  DB, P3));
    vecs.push_back(mk("hold",    0, 0, 0, Z,  0, Z,  Z,  0, 0, 0, Z,  DB, P3));
    vecs.push_back(mk("ld0_rd",  0, 1, 0, PF, 0, Z,  Z,  1, 0, 0, Z,  DB, P3));
    vecs.push_back(mk("rd_r0",   0, 0, 0, Z,  0, Z,  Z,  1, 0, 0, PF, DB, P3));
    vecs.push_back(mk("st_r1",   0, 0, 0, Z,  0, Z,  Z,  0, 1, 1, PF, DB, DB));
    vecs.push_back(mk("st0_rd",  0, 0, 0, Z,  0, Z,  Z,  1, 1, 0, PF, DB, PF));

    reset = 0;
    repeat (3) @(posedge clk);
    #1;
    cmp("in_reset_a1", A1, Z);
    cmp("in_reset_sd", store_data, Z);
    @(negedge clk);
    reset = 1;

    foreach (vecs[i]) apply(vecs[i]);

    // Asynchronous reset between edges while a load is pending.
    @(negedge clk);
    idle_inputs();
    load = 1; load_addr_reg = 0; load_data = rep(32'hFFFF_FFFF);
    #2;
    reset = 0;
    #1;
    cmp("async_rst_a1", A1, Z);
    cmp("async_rst_a2", A2, Z);
    cmp("async_rst_sd", store_data, Z);
    @(posedge clk);
    #1;
    cmp("rst_edge_sd", store_data, Z);
    @(negedge clk);
    reset = 1;
    idle_inputs();
    apply(mk("post_rst_r0", 0, 0, 0, Z, 0, Z, Z, 1, 1, 0, Z, Z, Z));
    apply(mk("post_rst_r2", 0, 0, 0, Z, 0, Z, Z, 0, 1, 2, Z, Z, Z));

    // random_set together with load and write_enable in the same cycle.
    w_snap = m_lfsr;
`ifdef REGFILE_RANDOM_SET_EN
    for (int i = 0; i < 4; i++) exp_r[i] = rep(w_snap ^ mix[i]);
`else
    exp_r[0] = Z; exp_r[1] = CF; exp_r[2] = P1; exp_r[3] = P2;
`endif
    apply(mk("rnd_fill", 1, 1, 1, CF, 1, P1, P2, 0, 0, 0, Z, Z, Z));
    for (int i = 0; i < 4; i++) begin
      apply(mk($sformatf("rnd_st%0d", i), 0, 0, 0, Z, 0, Z, Z, 0, 1, i[1:0], Z, Z, exp_r[i]));
    end
`ifdef REGFILE_RANDOM_SET_EN
    for (int i = 0; i < 4; i++) begin
      check_true($sformatf("rnd_nonzero%0d", i), exp_r[i] != Z);
      for (int j = i + 1; j < 4; j++) begin
        check_true($sformatf("rnd_distinct%0d%0d", i, j), exp_r[i] != exp_r[j]);
      end
    end
`endif

    @(negedge clk);
    idle_inputs();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
